// File: rtl/umi_reg_host_pkg.sv
// Shared UMI message definitions for the register host: opcodes, command
// field offsets, completion status codes and the host FSM state type.
package umi_reg_host_pkg;

    // UMI request/response opcodes (cmd[4:0])
    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    // Command field offsets
    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_SIZE_LSB   = 5;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_QOS_LSB    = 16;
    localparam int UMI_PROT_LSB   = 20;
    localparam int UMI_EOM_BIT    = 22;
    localparam int UMI_EOF_BIT    = 23;
    localparam int UMI_EX_BIT     = 24;
    localparam int UMI_ERR_LSB    = 25;
    localparam int UMI_HOSTID_LSB = 27;

    // Completion status codes (also the response cmd[26:25] encoding)
    localparam logic [1:0] UMI_ERR_OK     = 2'b00;
    localparam logic [1:0] UMI_ERR_EXOK   = 2'b01;
    localparam logic [1:0] UMI_ERR_DEVERR = 2'b10;
    localparam logic [1:0] UMI_ERR_NETERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Single-beat request command: LEN/QOS/EX/user fields are zero, EOM/EOF set.
    function automatic logic [31:0] umi_build_cmd(input logic [4:0] opcode,
                                                  input logic [2:0] size,
                                                  input logic [1:0] prot,
                                                  input logic [4:0] hostid);
        logic [31:0] c;
        c = '0;
        c[UMI_OPCODE_LSB +: 5] = opcode;
        c[UMI_SIZE_LSB +: 3]   = size;
        c[UMI_PROT_LSB +: 2]   = prot;
        c[UMI_EOM_BIT]         = 1'b1;
        c[UMI_EOF_BIT]         = 1'b1;
        c[UMI_HOSTID_LSB +: 5] = hostid;
        return c;
    endfunction

endpackage

// File: rtl/umi_reg_host_if.sv
// UMI host port bundle: request channel out, response channel in.
// Handshake: a beat transfers on a cycle where valid and ready are both high;
// the sender holds valid and payload stable until that cycle, and valid never
// depends combinationally on ready.
interface umi_reg_host_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 32
);
    import umi_reg_host_pkg::*;

    logic          uhost_req_valid;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr;
    logic [AW-1:0] uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_req_ready;

    logic          uhost_resp_valid;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr;
    logic [AW-1:0] uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;
    logic          uhost_resp_ready;

    modport master (
        output uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr,
               uhost_req_srcaddr, uhost_req_data,
        input  uhost_req_ready,
        input  uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr,
               uhost_resp_srcaddr, uhost_resp_data,
        output uhost_resp_ready
    );

    modport slave (
        input  uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr,
               uhost_req_srcaddr, uhost_req_data,
        output uhost_req_ready,
        output uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr,
               uhost_resp_srcaddr, uhost_resp_data,
        input  uhost_resp_ready
    );

endinterface

// File: rtl/umi_reg_host.sv
// Host-side UMI register initiator: turns one local read/write/posted-write
// request into a single-beat UMI request and returns the completion.
module umi_reg_host
    import umi_reg_host_pkg::*;
#(
    parameter int RW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_valid,
    input  logic          reg_write,
    input  logic          reg_posted,
    input  logic [AW-1:0] reg_addr,
    input  logic [RW-1:0] reg_wrdata,
    input  logic [1:0]    reg_prot,
    output logic          reg_ready,
    output logic          reg_done,
    output logic [RW-1:0] reg_rddata,
    output logic [1:0]    reg_err,
    input  logic [AW-1:0] host_srcaddr,
    input  logic [4:0]    host_id,
    umi_reg_host_if.master uhost,
    output state_t        dbg_state
);

    // Timer saturates at all-ones; TIMEOUT fits, so it never wraps early.
    localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [2:0]    SIZE       = 3'($clog2(RW / 8));

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [CW-1:0] cmd_q;
    logic [AW-1:0] dstaddr_q, srcaddr_q;
    logic [DW-1:0] data_q;
    logic [RW-1:0] rddata_q;
    logic [1:0]    err_q;
    logic [4:0]    new_op;
    logic [4:0]    req_op;
    logic          is_read, is_posted, resp_match, timed_out;

    assign req_op     = cmd_q[UMI_OPCODE_LSB +: 5];
    assign is_read    = (req_op == UMI_REQ_READ);
    assign is_posted  = (req_op == UMI_REQ_POSTED);
    assign resp_match = (uhost.uhost_resp_cmd[UMI_OPCODE_LSB +: 5] ==
                         (is_read ? UMI_RESP_READ : UMI_RESP_WRITE));
    assign timed_out  = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    // Request opcode chosen from the local request kind; posted is write-only.
    always_comb begin
        new_op = UMI_REQ_READ;
        if (reg_write) begin
            new_op = reg_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE;
        end
    end

    // FSM state register; reset silently drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a response beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (reg_valid) state_d = ST_REQ;
            ST_REQ: begin
                if (uhost.uhost_req_ready) state_d = is_posted ? ST_DONE : ST_RESP;
            end
            ST_RESP: begin
                if (uhost.uhost_resp_valid || timed_out) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request payload captured at acceptance and held through REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q     <= '0;
            dstaddr_q <= '0;
            srcaddr_q <= '0;
            data_q    <= '0;
        end else if (state_q == ST_IDLE && reg_valid) begin
            cmd_q     <= CW'(umi_build_cmd(new_op, SIZE, reg_prot, host_id));
            dstaddr_q <= reg_addr;
            srcaddr_q <= host_srcaddr;
            data_q    <= DW'(reg_wrdata);
        end
    end

    // Response wait timer: cleared on the request handshake, counts in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (state_q == ST_REQ && uhost.uhost_req_ready) begin
            timer_q <= '0;
        end else if (state_q == ST_RESP && timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Completion data/status; read data only changes on a read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rddata_q <= '0;
            err_q    <= UMI_ERR_OK;
        end else if (state_q == ST_REQ && uhost.uhost_req_ready && is_posted) begin
            err_q <= UMI_ERR_OK;
        end else if (state_q == ST_RESP) begin
            if (uhost.uhost_resp_valid) begin
                if (is_read) rddata_q <= uhost.uhost_resp_data[RW-1:0];
                err_q <= resp_match ? uhost.uhost_resp_cmd[UMI_ERR_LSB +: 2]
                                    : UMI_ERR_DEVERR;
            end else if (timed_out) begin
                err_q <= UMI_ERR_NETERR;
            end
        end
    end

    assign reg_ready               = (state_q == ST_IDLE);
    assign reg_done                = (state_q == ST_DONE);
    assign reg_rddata              = rddata_q;
    assign reg_err                 = err_q;
    assign uhost.uhost_req_valid   = (state_q == ST_REQ);
    assign uhost.uhost_req_cmd     = cmd_q;
    assign uhost.uhost_req_dstaddr = dstaddr_q;
    assign uhost.uhost_req_srcaddr = srcaddr_q;
    assign uhost.uhost_req_data    = data_q;
    assign uhost.uhost_resp_ready  = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign dbg_state               = state_q;

    // Response address fields and unused command/data bits are not consulted.
    logic unused_resp;
    assign unused_resp = ^{uhost.uhost_resp_dstaddr, uhost.uhost_resp_srcaddr,
                           uhost.uhost_resp_cmd, uhost.uhost_resp_data};

endmodule

// File: tb/tb_umi_reg_host.sv
// Bench for umi_reg_host: directed vector table, randomized transactions
// against a reference model, timeout/late-response and reset-abort sequences.
module tb_umi_reg_host;
    import umi_reg_host_pkg::*;

    localparam int TIMEOUT = 16;

    // Independent UMI opcode values used by the reference model
    localparam logic [4:0] OP_RD      = 5'h01;
    localparam logic [4:0] OP_WR      = 5'h03;
    localparam logic [4:0] OP_POSTED  = 5'h05;
    localparam logic [4:0] OP_RESP_RD = 5'h02;
    localparam logic [4:0] OP_RESP_WR = 5'h04;

    typedef struct {
        logic        write;
        logic        posted;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [1:0]  prot;
        int          stall;
        int          delay;     // RESP cycles before the response; >= TIMEOUT means none
        logic [4:0]  resp_op;
        logic [1:0]  resp_err;
        logic [31:0] resp_data;
        logic [31:0] exp_rddata;
        logic [1:0]  exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_valid, reg_write, reg_posted;
    logic [63:0] reg_addr, host_srcaddr;
    logic [31:0] reg_wrdata;
    logic [1:0]  reg_prot;
    logic        reg_ready, reg_done;
    logic [31:0] reg_rddata;
    logic [1:0]  reg_err;
    logic [4:0]  host_id;
    state_t      dbg_state;

    umi_reg_host_if #(.CW(32), .AW(64), .DW(32)) uhost ();

    umi_reg_host #(.RW(32), .TIMEOUT(TIMEOUT), .CW(32), .AW(64), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .reg_valid(reg_valid), .reg_write(reg_write), .reg_posted(reg_posted),
        .reg_addr(reg_addr), .reg_wrdata(reg_wrdata), .reg_prot(reg_prot),
        .reg_ready(reg_ready), .reg_done(reg_done), .reg_rddata(reg_rddata),
        .reg_err(reg_err), .host_srcaddr(host_srcaddr), .host_id(host_id),
        .uhost(uhost.master), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int n_total = 0;
    int n_pass = 0;
    int done_seen = 0;
    int done_expected = 0;
    logic [31:0] model_rd = '0;

    always @(negedge clk) if (reg_done) done_seen++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: completion status from the response rules.
    function automatic vec_t model_fill(input vec_t v, input logic [31:0] prev_rd);
        vec_t r;
        logic is_read;
        r = v;
        is_read = !v.write;
        r.exp_rddata = prev_rd;
        r.exp_err = 2'b00;
        if (v.write && v.posted) begin
            r.exp_err = 2'b00;
        end else if (v.delay >= TIMEOUT) begin
            r.exp_err = 2'b11;
        end else begin
            if (is_read) r.exp_rddata = v.resp_data;
            r.exp_err = (v.resp_op == (is_read ? OP_RESP_RD : OP_RESP_WR)) ? v.resp_err : 2'b10;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic w, input logic p, input logic [63:0] a,
                                input logic [31:0] wd, input logic [1:0] pr, input int st,
                                input int dl, input logic [4:0] rop, input logic [1:0] rerr,
                                input logic [31:0] rdat, input logic [31:0] erd,
                                input logic [1:0] eerr);
        vec_t v;
        v.write = w; v.posted = p; v.addr = a; v.wdata = wd; v.prot = pr;
        v.stall = st; v.delay = dl; v.resp_op = rop; v.resp_err = rerr;
        v.resp_data = rdat; v.exp_rddata = erd; v.exp_err = eerr;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_done(input string tag);
        logic [33:0] e;
        chk({tag, " done"}, reg_done, 1);
        chk({tag, " ready_in_done"}, reg_ready, 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, " rddata"}, reg_rddata, e[33:2]);
            chk({tag, " err"}, reg_err, e[1:0]);
        end
        @(negedge clk);
        chk({tag, " done_pulse"}, reg_done, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [4:0]  op;
        logic [31:0] exp_cmd;
        logic [63:0] acc_src;
        logic [4:0]  acc_id;
        logic        posted;
        int          cnt;
        posted = v.write && v.posted;
        op = !v.write ? OP_RD : (v.posted ? OP_POSTED : OP_WR);
        acc_src = {$urandom, $urandom};
        acc_id = 5'($urandom_range(0, 31));
        exp_cmd = {acc_id, 2'b00, 1'b0, 1'b1, 1'b1, v.prot, 4'h0, 8'h00, 3'd2, op};
        exp_q.push_back({v.exp_rddata, v.exp_err});
        done_expected++;
        cnt = 0;
        while (!reg_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, " idle_ready"}, reg_ready, 1);
        reg_valid = 1'b1; reg_write = v.write; reg_posted = v.posted;
        reg_addr = v.addr; reg_wrdata = v.wdata; reg_prot = v.prot;
        host_srcaddr = acc_src; host_id = acc_id;
        @(negedge clk);
        // Scramble local inputs: the request must come from captured state.
        reg_valid = 1'b0; reg_addr = {$urandom, $urandom}; reg_wrdata = $urandom;
        reg_prot = 2'($urandom_range(0, 3)); host_srcaddr = {$urandom, $urandom};
        host_id = 5'($urandom_range(0, 31));
        for (int i = 0; i <= v.stall; i++) begin
            chk({tag, " req_valid"}, uhost.uhost_req_valid, 1);
            chk({tag, " req_cmd"}, uhost.uhost_req_cmd, exp_cmd);
            chk({tag, " req_dst"}, uhost.uhost_req_dstaddr, v.addr);
            chk({tag, " req_src"}, uhost.uhost_req_srcaddr, acc_src);
            chk({tag, " req_data"}, uhost.uhost_req_data, v.wdata);
            chk({tag, " resp_ready_in_req"}, uhost.uhost_resp_ready, 0);
            if (i == v.stall) uhost.uhost_req_ready = 1'b1;
            @(negedge clk);
        end
        uhost.uhost_req_ready = 1'b0;
        if (posted) begin
            check_done(tag);
        end else if (v.delay >= TIMEOUT) begin
            cnt = 0;
            while (!reg_done && cnt < 100) begin
                chk({tag, " resp_ready_wait"}, uhost.uhost_resp_ready, 1);
                @(negedge clk);
                cnt++;
            end
            chk({tag, " timeout_edges"}, cnt, TIMEOUT);
            check_done(tag);
        end else begin
            for (int d = 0; d < v.delay; d++) begin
                chk({tag, " no_early_done"}, reg_done, 0);
                chk({tag, " resp_ready_wait"}, uhost.uhost_resp_ready, 1);
                @(negedge clk);
            end
            uhost.uhost_resp_valid = 1'b1;
            uhost.uhost_resp_cmd = {5'd0, v.resp_err, 20'h00000, v.resp_op};
            uhost.uhost_resp_data = v.resp_data;
            chk({tag, " resp_ready"}, uhost.uhost_resp_ready, 1);
            @(negedge clk);
            uhost.uhost_resp_valid = 1'b0;
            uhost.uhost_resp_data = $urandom;
            check_done(tag);
        end
        model_rd = v.exp_rddata;
    endtask

    // ---------------- test ----------------
    vec_t vecs[9];
    vec_t v;

    initial begin
        reset = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_posted = 1'b0;
        reg_addr = '0; reg_wrdata = '0; reg_prot = '0; host_srcaddr = '0; host_id = '0;
        uhost.uhost_req_ready = 1'b0; uhost.uhost_resp_valid = 1'b0;
        uhost.uhost_resp_cmd = '0; uhost.uhost_resp_dstaddr = '0;
        uhost.uhost_resp_srcaddr = '0; uhost.uhost_resp_data = '0;

        vecs[0] = mk(0, 0, 64'h1000, 32'h0, 2'd0, 0, 3, OP_RESP_RD, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        vecs[1] = mk(1, 1, 64'h20, 32'hA5A5A5A5, 2'd1, 4, 0, 5'd0, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00);
        vecs[2] = mk(1, 0, 64'h40, 32'h12345678, 2'd2, 1, 2, OP_RESP_WR, 2'b10, 32'hFFFFFFFF, 32'hDEADBEEF, 2'b10);
        vecs[3] = mk(0, 0, 64'h44, 32'h0, 2'd0, 0, 1, OP_RESP_WR, 2'b00, 32'h11112222, 32'h11112222, 2'b10);
        vecs[4] = mk(0, 0, 64'h48, 32'h0, 2'd3, 2, 15, OP_RESP_RD, 2'b01, 32'hCAFEF00D, 32'hCAFEF00D, 2'b01);
        vecs[5] = mk(1, 0, 64'h4C, 32'h55AA55AA, 2'd0, 0, 0, OP_RESP_WR, 2'b11, 32'h0, 32'hCAFEF00D, 2'b11);
        vecs[6] = mk(1, 0, 64'h50, 32'h0BADF00D, 2'd1, 0, 1, OP_RESP_RD, 2'b00, 32'h77777777, 32'hCAFEF00D, 2'b10);
        vecs[7] = mk(0, 1, 64'hFFFF_0000_0000_0004, 32'h0, 2'd2, 1, 5, OP_RESP_RD, 2'b00, 32'h5A5A0001, 32'h5A5A0001, 2'b00);
        vecs[8] = mk(0, 0, 64'h60, 32'h0, 2'd0, 0, 99, 5'd0, 2'b00, 32'h0, 32'h5A5A0001, 2'b11);

        repeat (3) @(negedge clk);
        chk("rst ready", reg_ready, 1);
        chk("rst done", reg_done, 0);
        chk("rst rddata", reg_rddata, 0);
        chk("rst err", reg_err, 0);
        chk("rst req_valid", uhost.uhost_req_valid, 0);
        chk("rst resp_ready", uhost.uhost_resp_ready, 1);
        chk("rst req_cmd", uhost.uhost_req_cmd, 0);
        chk("rst state", dbg_state, ST_IDLE);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Late response after the timeout: consumed in IDLE, no completion.
        uhost.uhost_resp_valid = 1'b1;
        uhost.uhost_resp_cmd = {5'd0, 2'b00, 20'h0, OP_RESP_RD};
        uhost.uhost_resp_data = 32'h0DDBA11;
        chk("late resp_ready", uhost.uhost_resp_ready, 1);
        @(negedge clk);
        uhost.uhost_resp_valid = 1'b0;
        chk("late no_done", reg_done, 0);
        chk("late ready", reg_ready, 1);
        chk("late rddata", reg_rddata, 32'h5A5A0001);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            v.write = 1'($urandom_range(0, 1));
            v.posted = 1'($urandom_range(0, 1));
            v.addr = {$urandom, $urandom};
            v.wdata = $urandom;
            v.prot = 2'($urandom_range(0, 3));
            v.stall = $urandom_range(0, 3);
            v.delay = $urandom_range(0, 17);
            case ($urandom_range(0, 3))
                0, 1: v.resp_op = v.write ? OP_RESP_WR : OP_RESP_RD;
                2: v.resp_op = v.write ? OP_RESP_RD : OP_RESP_WR;
                default: v.resp_op = 5'h06;
            endcase
            v.resp_err = 2'($urandom_range(0, 3));
            v.resp_data = $urandom;
            v = model_fill(v, model_rd);
            run_vec(v, $sformatf("rand%0d", n));
        end

        // Reset while waiting in RESP, then a response arrives: silent abort.
        reg_valid = 1'b1; reg_write = 1'b0; reg_posted = 1'b0; reg_addr = 64'h3000;
        @(negedge clk);
        reg_valid = 1'b0;
        uhost.uhost_req_ready = 1'b1;
        @(negedge clk);
        uhost.uhost_req_ready = 1'b0;
        chk("abort in_resp", dbg_state, ST_RESP);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort ready", reg_ready, 1);
        chk("abort rddata", reg_rddata, 0);
        chk("abort err", reg_err, 0);
        chk("abort req_dst", uhost.uhost_req_dstaddr, 0);
        chk("abort state", dbg_state, ST_IDLE);
        reset = 1'b0;
        uhost.uhost_resp_valid = 1'b1;
        uhost.uhost_resp_cmd = {5'd0, 2'b00, 20'h0, OP_RESP_RD};
        uhost.uhost_resp_data = 32'hBAD0BAD0;
        chk("abort resp_ready", uhost.uhost_resp_ready, 1);
        @(negedge clk);
        uhost.uhost_resp_valid = 1'b0;
        chk("abort no_done", reg_done, 0);
        chk("abort rddata_kept", reg_rddata, 0);
        model_rd = '0;
        run_vec(mk(0, 0, 64'h3004, 32'h0, 2'd0, 0, 2, OP_RESP_RD, 2'b00, 32'h600DCAFE,
                   32'h600DCAFE, 2'b00), "post_abort");

        repeat (2) @(negedge clk);
        chk("done_count", done_seen, done_expected);
        chk("exp_q_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/umi_reg_host.md
Name: umi_reg_host

Overview:
- Host-side UMI initiator. Converts a simple local register request (read, write or posted write) into a single-beat UMI request on uhost_req_*.
- For reads and writes, waits for the UMI response on uhost_resp_* and returns read data and error status to the local master.
- Counterpart of the device-side register bridge. Used by on-chip controllers (boot sequencers, test engines) to reach UMI register targets.
- One transaction outstanding at a time; no atomics; no multi-beat transfers.

Parameters:
- RW, 32, register/data width in bits; must be <= DW; power of 2, >= 8
- TIMEOUT, 1024, response wait limit in cycles; 0 disables the timeout
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 32, UMI data width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- reg_valid  input  1  local request valid
- reg_write  input  1  1=write, 0=read (sampled with reg_valid)
- reg_posted  input  1  write is posted (no response); ignored for reads
- reg_addr  input  AW  target address
- reg_wrdata  input  RW  write data
- reg_prot  input  2  protection, placed in cmd[21:20]
- reg_ready  output  1  bridge idle, request accepted when reg_valid & reg_ready
- reg_done  output  1  one-cycle completion pulse
- reg_rddata  output  RW  read data, valid with reg_done
- reg_err  output  2  completion status, valid with reg_done
- host_srcaddr  input  AW  return address placed in request srcaddr
- host_id  input  5  host ID placed in cmd[31:27]
- uhost_req_valid  output  1  UMI request valid
- uhost_req_cmd  output  CW  UMI request command
- uhost_req_dstaddr  output  AW  request destination
- uhost_req_srcaddr  output  AW  request source
- uhost_req_data  output  DW  request data, zero-extended from RW
- uhost_req_ready  input  1  UMI request ready
- uhost_resp_valid  input  1  UMI response valid
- uhost_resp_cmd  input  CW  response command
- uhost_resp_dstaddr  input  AW  response destination (unused)
- uhost_resp_srcaddr  input  AW  response source (unused)
- uhost_resp_data  input  DW  response data
- uhost_resp_ready  output  1  UMI response ready

Behaviour:
- Reset values: state=IDLE; reg_ready=1; reg_done=0; reg_rddata=0; reg_err=0; uhost_req_valid=0; uhost_resp_ready=1; timer=0; all uhost_req_* payload registers=0.
- Reset mid-transaction aborts the transaction silently, with no reg_done. A response arriving afterwards is drained in IDLE.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - reg_ready=1 and uhost_resp_ready=1; stray responses are consumed and discarded.
  - On reg_valid: register addr, data and command; go to REQ.
- Command encoding:
  - cmd[4:0] opcode: read=UMI_REQ_READ, write=UMI_REQ_WRITE, posted=UMI_REQ_POSTED.
  - cmd[7:5] SIZE = log2(RW/8); cmd[15:8] LEN = 0; cmd[19:16] QOS = 0; cmd[21:20] = reg_prot.
  - cmd[22] EOM = 1; cmd[23] EOF = 1; cmd[24] EX = 0; cmd[26:25] = 0; cmd[31:27] = host_id.
- REQ:
  - uhost_req_valid=1 with payload held stable until uhost_req_ready. The first valid is one cycle after acceptance.
  - On handshake: a posted write goes to DONE with err=00. Read or write goes to RESP and clears the timer.
  - reg_ready=0; uhost_resp_ready=0.
- RESP:
  - uhost_resp_ready=1; timer increments each cycle.
  - On uhost_resp_valid, capture reg_rddata = resp_data[RW-1:0] for reads (unchanged for writes) and set reg_err:
    - opcode matches expected (UMI_RESP_READ for read, UMI_RESP_WRITE for write): reg_err = resp_cmd[26:25]
    - opcode mismatch: reg_err = 2'b10
  - Then go to DONE.
  - If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no response: reg_err=2'b11, reg_rddata unchanged, go to DONE. A late response is later discarded in IDLE.
  - A response and the timeout expiring in the same cycle: the response wins.
- DONE: reg_done=1 for exactly one cycle, then IDLE. reg_ready=0 in DONE, so back-to-back requests have a minimum gap.
- Latency:
  - Posted write: accept at t0, req_valid at t0+1, done at t0+2 with zero-wait ready.
  - Read with response in cycle tr: done at tr+1.
- Timer width: clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- UMI opcode constants (UMI_REQ_*, UMI_RESP_*) and cmd field offsets come from the shared umi_messages.vh package. Add an error-code localparam set there (OK=00, EXOK=01, DEVERR=10, NETERR=11).
- No sub-module; the FSM and timer are a single module.

Test Plan:
- Read addr 0x1000, device responds UMI_RESP_READ with data 0xDEADBEEF, err 00, 3 cycles later -> uhost_req_cmd[4:0]=UMI_REQ_READ, SIZE=2, EOM=1, dstaddr=0x1000; reg_done once with reg_rddata=0xDEADBEEF and reg_err=00.
- Posted write 0xA5A5A5A5 to 0x20 with uhost_req_ready low for 4 cycles -> payload stable while stalled; reg_done 1 cycle after handshake with err=00; uhost_resp_ready stays 0 during REQ.
- Write with response err=10 -> reg_done with reg_err=10; reg_rddata keeps its previous value.
- TIMEOUT=16, read with no response -> reg_done exactly 16 cycles after the request handshake with reg_err=11. A late response then arrives in IDLE -> it is consumed (resp_ready=1) and produces no reg_done.
- Read answered by UMI_RESP_WRITE opcode -> reg_err=10.
- Reset asserted in RESP, then a response arrives -> no reg_done; outputs return to reset values; the next read completes normally.
